// File: rtl/lector_pkg.sv
// Shared types and defaults for the BufferCircular read engine.
package lector_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEER   = 2'd1,
        DRENAR = 2'd2
    } estado_t;

    localparam int NUM   = 8;
    localparam int BW    = $clog2(NUM + 1);
    localparam int CNT_W = 32;

    // Saturate a requested burst length at the buffer depth.
    function automatic int unsigned limitar(input int unsigned rafaga, input int unsigned maximo);
        if (rafaga > maximo) begin
            return maximo;
        end else begin
            return rafaga;
        end
    endfunction

endpackage

// File: rtl/lector_buffer_circular_etapa_salida.sv
// One-entry output register: loads a popped word, holds it while downstream stalls,
// and empties on a transfer that is not refilled in the same cycle.
module etapa_salida #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             carga_i,
    input  logic             acepta_i,
    input  logic [WIDTH-1:0] dato_i,
    input  logic             ultimo_i,
    output logic [WIDTH-1:0] dato_o,
    output logic             valido_o,
    output logic             ultimo_o
);

    logic [WIDTH-1:0] dato_q, dato_d;
    logic             valido_q, valido_d;
    logic             ultimo_q, ultimo_d;

    // Next-entry selection: load wins over drain, otherwise hold.
    always_comb begin
        dato_d   = dato_q;
        valido_d = valido_q;
        ultimo_d = ultimo_q;
        if (carga_i) begin
            dato_d   = dato_i;
            valido_d = 1'b1;
            ultimo_d = ultimo_i;
        end else if (valido_q && acepta_i) begin
            valido_d = 1'b0;
            ultimo_d = 1'b0;
        end else begin
            valido_d = valido_q;
        end
    end

    // Entry registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dato_q   <= {WIDTH{1'b0}};
            valido_q <= 1'b0;
            ultimo_q <= 1'b0;
        end else begin
            dato_q   <= dato_d;
            valido_q <= valido_d;
            ultimo_q <= ultimo_d;
        end
    end

    assign dato_o   = dato_q;
    assign valido_o = valido_q;
    assign ultimo_o = ultimo_q;

endmodule

// File: rtl/lector_buffer_circular.sv
// Burst reader for a first-word-fall-through circular buffer: pops the requested
// number of words and streams them out over valid/ready at one word per clock.
module lector_buffer_circular #(
    parameter  int WIDTH = 64,
    parameter  int NUM   = lector_pkg::NUM,
    parameter  int CNT_W = lector_pkg::CNT_W,
    localparam int BW    = $clog2(NUM + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             peticion_i,
    input  logic [BW-1:0]    rafaga_i,
    output logic             pet_lista_o,
    input  logic             vacia_i,
    input  logic [WIDTH-1:0] dato_i,
    output logic             delecion_o,
    output logic [WIDTH-1:0] dato_o,
    output logic             valido_o,
    input  logic             listo_i,
    output logic             ultimo_o,
    output logic [CNT_W-1:0] contador_o
);
    import lector_pkg::*;

    localparam logic [BW-1:0]    RESTANTES_CERO = {BW{1'b0}};
    localparam logic [BW-1:0]    RESTANTES_UNO  = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CONTADOR_UNO   = {{(CNT_W-1){1'b0}}, 1'b1};

    estado_t          estado_q, estado_d;
    logic [BW-1:0]    restantes_q, restantes_d;
    logic [CNT_W-1:0] contador_q, contador_d;

    logic             pop_s;
    logic             transfer_s;
    logic             ultimo_carga_s;
    logic             valido_s;
    logic             ultimo_s;
    logic [WIDTH-1:0] dato_s;

    assign transfer_s     = valido_s && listo_i;
    assign ultimo_carga_s = (restantes_q == RESTANTES_UNO);

    // Pop only when a word is there, the burst is unfinished and the output slot frees up this cycle.
    always_comb begin
        pop_s = 1'b0;
        if (!rst_i && (estado_q == LEER) && !vacia_i &&
            (restantes_q != RESTANTES_CERO) && (!valido_s || listo_i)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Burst sequencing and remaining-word bookkeeping.
    always_comb begin
        estado_d    = estado_q;
        restantes_d = restantes_q;
        case (estado_q)
            IDLE: begin
                if (peticion_i) begin
                    restantes_d = BW'(limitar(int'(rafaga_i), NUM));
                    if (rafaga_i != RESTANTES_CERO) begin
                        estado_d = LEER;
                    end else begin
                        estado_d = IDLE;
                    end
                end else begin
                    estado_d = IDLE;
                end
            end
            LEER: begin
                if (pop_s) begin
                    restantes_d = restantes_q - RESTANTES_UNO;
                    if (ultimo_carga_s) begin
                        estado_d = DRENAR;
                    end else begin
                        estado_d = LEER;
                    end
                end else begin
                    estado_d = LEER;
                end
            end
            DRENAR: begin
                if (transfer_s) begin
                    estado_d = IDLE;
                end else begin
                    estado_d = DRENAR;
                end
            end
            default: begin
                estado_d    = IDLE;
                restantes_d = RESTANTES_CERO;
            end
        endcase
    end

    // Delivered-word counter, free-running modulo 2^CNT_W.
    always_comb begin
        if (transfer_s) begin
            contador_d = contador_q + CONTADOR_UNO;
        end else begin
            contador_d = contador_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            estado_q    <= IDLE;
            restantes_q <= RESTANTES_CERO;
            contador_q  <= {CNT_W{1'b0}};
        end else begin
            estado_q    <= estado_d;
            restantes_q <= restantes_d;
            contador_q  <= contador_d;
        end
    end

    etapa_salida #(
        .WIDTH (WIDTH)
    ) u_etapa_salida (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .carga_i  (pop_s),
        .acepta_i (listo_i),
        .dato_i   (dato_i),
        .ultimo_i (ultimo_carga_s),
        .dato_o   (dato_s),
        .valido_o (valido_s),
        .ultimo_o (ultimo_s)
    );

    assign pet_lista_o = (estado_q == IDLE);
    assign delecion_o  = pop_s;
    assign dato_o      = dato_s;
    assign valido_o    = valido_s;
    assign ultimo_o    = ultimo_s;
    assign contador_o  = contador_q;

endmodule

// File: tb/tb_lector_buffer_circular.sv
// Directed bench for lector_buffer_circular, with an 8-deep FWFT circular buffer
// modelled in place of BufferCircular.
module tb_lector_buffer_circular;

    localparam int WIDTH = 64;
    localparam int NUM   = 8;
    localparam int BW    = 4;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             peticion = 1'b0;
    logic [BW-1:0]    rafaga = 4'd0;
    logic             pet_lista;
    logic             vacia;
    logic [WIDTH-1:0] buf_dato;
    logic             delecion;
    logic [WIDTH-1:0] dato;
    logic             valido;
    logic             listo = 1'b1;
    logic             ultimo;
    logic [CNT_W-1:0] contador;

    // Buffer model
    logic [WIDTH-1:0] mem [NUM];
    logic [2:0]       rd = 3'd0;
    logic [2:0]       wr = 3'd0;
    int               buf_cnt = 0;
    logic             ins = 1'b0;
    logic [WIDTH-1:0] ins_dato = 64'd0;

    // Monitor state
    logic [WIDTH:0]   entregados [$];
    int               ciclos [$];
    int               ciclo = 0;
    int               pops = 0;
    int               viol = 0;

    int               n_checks = 0;
    int               n_fail = 0;
    longint           exp_cnt = 0;

    always #5 clk = ~clk;

    assign vacia    = (buf_cnt == 0);
    assign buf_dato = mem[rd];

    lector_buffer_circular #(
        .WIDTH (WIDTH),
        .NUM   (NUM),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .peticion_i  (peticion),
        .rafaga_i    (rafaga),
        .pet_lista_o (pet_lista),
        .vacia_i     (vacia),
        .dato_i      (buf_dato),
        .delecion_o  (delecion),
        .dato_o      (dato),
        .valido_o    (valido),
        .listo_i     (listo),
        .ultimo_o    (ultimo),
        .contador_o  (contador)
    );

    always @(posedge clk) begin
        if (delecion && buf_cnt > 0) rd <= rd + 3'd1;
        if (ins) begin
            mem[wr] <= ins_dato;
            wr      <= wr + 3'd1;
        end
        buf_cnt <= buf_cnt + (ins ? 1 : 0) - ((delecion && buf_cnt > 0) ? 1 : 0);
    end

    always @(posedge clk) begin
        ciclo <= ciclo + 1;
        if (valido && listo) begin
            entregados.push_back({ultimo, dato});
            ciclos.push_back(ciclo);
        end
        if (delecion) begin
            pops <= pops + 1;
            if ((valido && !listo) || buf_cnt == 0) viol <= viol + 1;
        end
    end

    task automatic comprobar(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        n_checks++;
        if (obs !== esp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic llenar(input int a, input int b);
        for (int v = a; v <= b; v++) begin
            ins      = 1'b1;
            ins_dato = 64'(v);
            @(negedge clk);
        end
        ins = 1'b0;
    endtask

    task automatic pedir(input int n);
        peticion = 1'b1;
        rafaga   = 4'(n);
        @(negedge clk);
        peticion = 1'b0;
        rafaga   = 4'd0;
    endtask

    task automatic esperar_fin(input string tag, input int lim);
        int k;
        k = 0;
        while (!(pet_lista && !valido) && k < lim) begin
            @(negedge clk);
            k++;
        end
        comprobar({tag, "_fin"}, 64'(pet_lista && !valido), 64'd1);
    endtask

    task automatic revisar_rafaga(input string tag, input int primero, input int n);
        comprobar({tag, "_num"}, 64'(entregados.size()), 64'(n));
        for (int i = 0; i < n && i < entregados.size(); i++) begin
            comprobar({tag, "_dato"}, entregados[i][63:0], 64'(primero + i));
            comprobar({tag, "_ult"}, 64'(entregados[i][64]), 64'(i == n - 1));
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        comprobar("rst_dato", dato, 64'd0);
        comprobar("rst_valido", 64'(valido), 64'd0);
        comprobar("rst_ultimo", 64'(ultimo), 64'd0);
        comprobar("rst_cont", 64'(contador), 64'd0);
        comprobar("rst_delecion", 64'(delecion), 64'd0);
        comprobar("rst_lista", 64'(pet_lista), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // 1: full burst of 8 at full rate
        entregados.delete(); ciclos.delete();
        llenar(1, 8);
        pedir(8);
        esperar_fin("t1", 40);
        revisar_rafaga("t1", 1, 8);
        if (ciclos.size() == 8) comprobar("t1_seguidos", 64'(ciclos[7] - ciclos[0]), 64'd7);
        exp_cnt += 8;
        comprobar("t1_cont", 64'(contador), 64'(exp_cnt));
        comprobar("t1_vacia", 64'(vacia), 64'd1);
        comprobar("t1_lista", 64'(pet_lista), 64'd1);

        // 2: buffer runs empty mid-burst, then refills
        entregados.delete();
        llenar(1, 4);
        pedir(6);
        repeat (10) @(negedge clk);
        comprobar("t2_parcial", 64'(entregados.size()), 64'd4);
        comprobar("t2_en_leer", 64'(pet_lista), 64'd0);
        llenar(5, 6);
        esperar_fin("t2", 40);
        revisar_rafaga("t2", 1, 6);
        exp_cnt += 6;
        comprobar("t2_cont", 64'(contador), 64'(exp_cnt));

        // 3: downstream stall holds the output with exactly one pop
        entregados.delete();
        llenar(1, 8);
        listo = 1'b0;
        pedir(3);
        repeat (5) @(negedge clk);
        comprobar("t3_dato", dato, 64'd1);
        comprobar("t3_valido", 64'(valido), 64'd1);
        comprobar("t3_un_pop", 64'(buf_cnt), 64'd7);
        listo = 1'b1;
        esperar_fin("t3", 40);
        revisar_rafaga("t3", 1, 3);
        comprobar("t3_quedan", 64'(buf_cnt), 64'd5);
        comprobar("t3_cabeza", buf_dato, 64'd4);
        exp_cnt += 3;
        entregados.delete();
        pedir(5);
        esperar_fin("t3b", 40);
        revisar_rafaga("t3b", 4, 5);
        exp_cnt += 5;
        comprobar("t3_cont", 64'(contador), 64'(exp_cnt));

        // 4: zero-length request is a no-op, then a normal burst; then an oversize request clamps
        entregados.delete();
        llenar(1, 8);
        begin
            int p0;
            p0 = pops;
            pedir(0);
            repeat (4) @(negedge clk);
            comprobar("t4_sin_pops", 64'(pops), 64'(p0));
        end
        comprobar("t4_valido", 64'(valido), 64'd0);
        comprobar("t4_lista", 64'(pet_lista), 64'd1);
        comprobar("t4_nada", 64'(entregados.size()), 64'd0);
        pedir(8);
        esperar_fin("t4", 40);
        revisar_rafaga("t4", 1, 8);
        exp_cnt += 8;
        entregados.delete();
        llenar(1, 8);
        pedir(15);
        esperar_fin("t4c", 40);
        revisar_rafaga("t4c", 1, 8);
        exp_cnt += 8;
        comprobar("t4_cont", 64'(contador), 64'(exp_cnt));

        // 5: reset after three transfers drops the in-flight word
        entregados.delete();
        llenar(1, 8);
        pedir(8);
        for (int k = 0; k < 20 && entregados.size() < 3; k++) @(negedge clk);
        comprobar("t5_tres", 64'(entregados.size()), 64'd3);
        rst   = 1'b1;
        listo = 1'b0;
        @(negedge clk);
        comprobar("t5_dato", dato, 64'd0);
        comprobar("t5_valido", 64'(valido), 64'd0);
        comprobar("t5_ultimo", 64'(ultimo), 64'd0);
        comprobar("t5_cont", 64'(contador), 64'd0);
        comprobar("t5_delecion", 64'(delecion), 64'd0);
        comprobar("t5_lista", 64'(pet_lista), 64'd1);
        comprobar("t5_quedan", 64'(buf_cnt), 64'd4);
        comprobar("t5_cabeza", buf_dato, 64'd5);
        rst   = 1'b0;
        listo = 1'b1;
        exp_cnt = 0;
        entregados.delete();
        pedir(4);
        esperar_fin("t5", 40);
        revisar_rafaga("t5", 5, 4);
        exp_cnt += 4;
        comprobar("t5_cont_fin", 64'(contador), 64'(exp_cnt));

        // 6: listo toggling every clock
        entregados.delete();
        llenar(1, 8);
        pedir(8);
        for (int k = 0; k < 60 && !(pet_lista && !valido); k++) begin
            listo = ~listo;
            @(negedge clk);
        end
        listo = 1'b1;
        esperar_fin("t6", 10);
        revisar_rafaga("t6", 1, 8);
        exp_cnt += 8;
        comprobar("t6_cont", 64'(contador), 64'(exp_cnt));
        comprobar("t6_vacia", 64'(vacia), 64'd1);
        comprobar("viol_pop", 64'(viol), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
